// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for one shared W-bit ALU.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   reqN/lN/opN    requester N request, mode (0 arith, 1 logic), op code
//   aN/bN          requester N operands (held stable until gntN)
//   gnt0/gnt1      one-cycle pulse: operands of that requester latched
//   done0/done1    one-cycle pulse: r/z/c/s hold that requester's result
//   r/z/c/s        registered result and zero/carry/sign flags
//   busy           high while the latched operation is executing
//
// Flow: IDLE samples the requests and latches the winner (gnt). The next
// edge (EXEC) registers the ALU outputs and pulses done, returning to IDLE,
// which may grant again at that same cycle's closing edge.

// Combinational W-bit ALU. Arithmetic ops are all formed as X + Y + cin on
// a (W+1)-bit adder so carry/sign come straight from the sum.
module alu #(
  parameter int W = 4
) (
  input  logic         i_l,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r,
  output logic         o_z,
  output logic         o_c,
  output logic         o_s
);
  logic [W-1:0] w_x, w_y, w_log;
  logic         w_cin;
  logic [W:0]   w_sum;

  always_comb begin
    w_x   = i_a;
    w_y   = i_b;
    w_cin = 1'b0;
    case (i_op)
      2'b00: begin w_x = ~i_a; w_y = '0;   w_cin = 1'b1; end  // -A
      2'b01: begin w_x = ~i_b; w_y = '0;   w_cin = 1'b1; end  // -B
      2'b10: begin                                      end  // A+B
      2'b11: begin              w_y = ~i_b; w_cin = 1'b1; end  // A-B
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_cin};

  always_comb begin
    w_log = i_a & i_b;
    case (i_op)
      2'b00: w_log = i_a & i_b;
      2'b01: w_log = i_a | i_b;
      2'b10: w_log = i_a ^ i_b;
      2'b11: w_log = ~i_a;
      default: ;
    endcase
  end

  assign o_r = i_l ? w_log : w_sum[W-1:0];
  assign o_z = ~|o_r;
  // Raw adder flags; meaningless in logic mode, the arbiter masks them.
  assign o_c = w_sum[W];
  assign o_s = w_sum[W-1];
endmodule

module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         l0,
  input  logic [1:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic         l1,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] r,
  output logic         z,
  output logic         c,
  output logic         s,
  output logic         busy
);
  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t       r_state, w_next;
  logic         r_ptr;      // requester favoured on a tie
  logic         r_sel;      // requester owning the operation in EXEC
  logic         r_gnt0, r_gnt1, r_done0, r_done1;
  logic         r_l;
  logic [1:0]   r_op;
  logic [W-1:0] r_a, r_b, r_r;
  logic         r_z, r_c, r_s;
  logic         w_grant0, w_grant1;
  logic [W-1:0] w_alu_r;
  logic         w_alu_z, w_alu_c, w_alu_s;

  alu #(.W(W)) u_alu (
    .i_l  (r_l),
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_r  (w_alu_r),
    .o_z  (w_alu_z),
    .o_c  (w_alu_c),
    .o_s  (w_alu_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Requests are only looked at in IDLE; a tie goes to r_ptr.
  always_comb begin
    w_next   = r_state;
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 && (!req1 || !r_ptr)) w_grant0 = 1'b1;
        else if (req1)                 w_grant1 = 1'b1;
        if (w_grant0 || w_grant1) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= 1'b0;
      r_sel   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_l     <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_z     <= 1'b1;
      r_c     <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_gnt0  <= w_grant0;
      r_gnt1  <= w_grant1;
      r_done0 <= (r_state == S_EXEC) && !r_sel;
      r_done1 <= (r_state == S_EXEC) &&  r_sel;
      if (w_grant0) begin
        r_l <= l0; r_op <= op0; r_a <= a0; r_b <= b0;
        r_sel <= 1'b0;
        r_ptr <= 1'b1;
      end else if (w_grant1) begin
        r_l <= l1; r_op <= op1; r_a <= a1; r_b <= b1;
        r_sel <= 1'b1;
        r_ptr <= 1'b0;
      end
      if (r_state == S_EXEC) begin
        r_r <= w_alu_r;
        r_z <= w_alu_z;
        r_c <= r_l ? 1'b0 : w_alu_c;
        r_s <= r_l ? 1'b0 : w_alu_s;
      end
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign r     = r_r;
  assign z     = r_z;
  assign c     = r_c;
  assign s     = r_s;
  assign busy  = (r_state == S_EXEC);
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, l0, req1, l1;
  logic [1:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, done0, done1, z, c, s, busy;
  logic [W-1:0] r;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;   // reference: requester that wins the next tie

  // Per-requester operand store used to drive the ports.
  logic       s_l  [2];
  logic [1:0] s_op [2];
  logic [3:0] s_a  [2];
  logic [3:0] s_b  [2];

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .l0(l0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .l1(l1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .r(r), .z(z), .c(c), .s(s), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference from the arithmetic meaning of each op, returns {r,z,c,s}.
  function automatic logic [6:0] model(input logic l, input logic [1:0] op,
                                       input logic [3:0] a, input logic [3:0] b);
    int ai, bi, res;
    logic cy, sg;
    ai = int'(a); bi = int'(b); cy = 1'b0; sg = 1'b0; res = 0;
    if (!l) begin
      case (op)
        2'd0: begin res = (16 - ai) % 16;      cy = (ai == 0);     end
        2'd1: begin res = (16 - bi) % 16;      cy = (bi == 0);     end
        2'd2: begin res = (ai + bi) % 16;      cy = (ai + bi) > 15; end
        default: begin res = (ai - bi + 16) % 16; cy = (ai >= bi); end
      endcase
      sg = (res >= 8);
    end else begin
      case (op)
        2'd0: res = ai & bi;
        2'd1: res = ai | bi;
        2'd2: res = ai ^ bi;
        default: res = 15 - ai;
      endcase
    end
    return {res[3:0], (res == 0), cy, sg};
  endfunction

  function automatic logic gnt_of(input int who);
    return (who == 1) ? gnt1 : gnt0;
  endfunction
  function automatic logic done_of(input int who);
    return (who == 1) ? done1 : done0;
  endfunction

  task automatic set_req(input int who, input logic v);
    if (who == 0) begin req0 = v; l0 = s_l[0]; op0 = s_op[0]; a0 = s_a[0]; b0 = s_b[0]; end
    else          begin req1 = v; l1 = s_l[1]; op1 = s_op[1]; a1 = s_a[1]; b1 = s_b[1]; end
  endtask

  task automatic load(input int who, input logic l, input logic [1:0] op,
                      input logic [3:0] a, input logic [3:0] b);
    s_l[who] = l; s_op[who] = op; s_a[who] = a; s_b[who] = b;
  endtask

  task automatic rand_load(input int who);
    load(who, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  // Single uncontended op from IDLE; called on a negedge, returns on a negedge.
  task automatic run_single(input int who, input logic [6:0] exp, input string name);
    int n = 0;
    set_req(who, 1'b1);
    do begin @(negedge clk); n++; end while (gnt_of(who) !== 1'b1 && n < 8);
    chk({name, " gnt"}, gnt_of(who), 1);
    chk({name, " gnt latency"}, n, 1);
    chk({name, " other gnt"}, gnt_of(1 - who), 0);
    chk({name, " busy"}, busy, 1);
    m_ptr = 1 - who;
    set_req(who, 1'b0);
    @(negedge clk);
    chk({name, " done"}, done_of(who), 1);
    chk({name, " other done"}, done_of(1 - who), 0);
    chk({name, " rzcs"}, {r, z, c, s}, exp);
    @(negedge clk);
    chk({name, " done pulse"}, done_of(who), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rzcs", {r, z, c, s}, 7'b0000_1_0_0);
    chk("reset gnt/done/busy", {gnt0, gnt1, done0, done1, busy}, 0);
    m_ptr = 0;
  endtask

  // Invariants checked every cycle out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        errors++;
        $display("FAIL invariant: gnt=%b%b done=%b%b required one-hot or zero", gnt0, gnt1, done0, done1);
      end
    end
  end

  typedef struct {
    int         who;
    logic       l;
    logic [1:0] op;
    logic [3:0] a, b;
    logic [3:0] r;
    logic       z, c, s;
  } vec_t;

  initial begin
    vec_t       tbl[7];
    logic [6:0] exp, last;
    int         pend[2];
    int         issued, guard, w, gap;

    tbl[0] = '{0, 1'b0, 2'b10, 4'b0101, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1, 1'b0, 2'b11, 4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{0, 1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{0, 1'b1, 2'b00, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1, 1'b1, 2'b11, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{0, 1'b0, 2'b01, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1, 1'b1, 2'b10, 4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0};

    load(0, 0, 0, 0, 0); load(1, 0, 0, 0, 0);
    set_req(0, 1'b0); set_req(1, 1'b0);
    do_reset();
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      load(tbl[i].who, tbl[i].l, tbl[i].op, tbl[i].a, tbl[i].b);
      run_single(tbl[i].who, {tbl[i].r, tbl[i].z, tbl[i].c, tbl[i].s}, $sformatf("vec%0d", i));
    end

    // Contention from reset: 0 wins, then 0 re-requests while 1 still waits -> 1 wins.
    do_reset();
    load(0, 0, 2'b10, 4'd1, 4'd2); load(1, 1, 2'b01, 4'd4, 4'd1);
    set_req(0, 1'b1); set_req(1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("cont e1 gnt", {gnt0, gnt1}, 2'b10);
    set_req(0, 1'b0);
    @(negedge clk);
    chk("cont e2 done0", {done0, done1}, 2'b10);
    chk("cont e2 rzcs", {r, z, c, s}, 7'b0011_0_0_0);
    load(0, 0, 2'b11, 4'd2, 4'd3);
    set_req(0, 1'b1);
    @(negedge clk);
    chk("cont e3 gnt1 first", {gnt0, gnt1}, 2'b01);
    set_req(1, 1'b0);
    @(negedge clk);
    chk("cont e4 done1", {done0, done1}, 2'b01);
    chk("cont e4 rzcs", {r, z, c, s}, 7'b0101_0_0_0);
    @(negedge clk);
    chk("cont e5 gnt", {gnt0, gnt1}, 2'b10);
    set_req(0, 1'b0);
    @(negedge clk);
    chk("cont e6 rzcs", {r, z, c, s}, 7'b1111_0_0_1);
    m_ptr = 1;
    @(negedge clk);

    // Randomized continuous contention: winner predicted from m_ptr.
    rand_load(0); rand_load(1);
    set_req(0, 1'b1); set_req(1, 1'b1);
    pend[0] = 1; pend[1] = 1; issued = 2; guard = 0;
    while ((pend[0] != 0 || pend[1] != 0) && guard < 60) begin
      guard++;
      w = (pend[0] != 0 && pend[1] != 0) ? m_ptr : ((pend[0] != 0) ? 0 : 1);
      @(negedge clk);
      chk($sformatf("rcont%0d gnt", guard), {gnt0, gnt1}, (w == 0) ? 2'b10 : 2'b01);
      m_ptr = 1 - w;
      set_req(w, 1'b0);
      pend[w] = 0;
      exp = model(s_l[w], s_op[w], s_a[w], s_b[w]);
      @(negedge clk);
      chk($sformatf("rcont%0d done", guard), {done0, done1}, (w == 0) ? 2'b10 : 2'b01);
      chk($sformatf("rcont%0d rzcs", guard), {r, z, c, s}, exp);
      if (issued < 14) begin
        rand_load(w); set_req(w, 1'b1); pend[w] = 1; issued++;
      end
    end
    @(negedge clk);

    // Random single ops with idle gaps; results must hold between dones.
    for (int k = 0; k < 20; k++) begin
      w = int'($urandom_range(0, 1));
      rand_load(w);
      exp = model(s_l[w], s_op[w], s_a[w], s_b[w]);
      run_single(w, exp, $sformatf("rnd%0d", k));
      last = exp;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      chk($sformatf("rnd%0d hold", k), {r, z, c, s}, last);
    end

    // Reset while EXEC: operation dropped, pointer back to 0.
    load(0, 0, 2'b10, 4'd7, 4'd7);
    set_req(0, 1'b1);
    @(negedge clk);
    chk("rst-exec gnt0", gnt0, 1);
    chk("rst-exec busy", busy, 1);
    reset = 1'b0;
    set_req(0, 1'b0);
    #1;
    chk("rst-exec outputs", {r, z, c, s, busy, gnt0}, 9'b0000_1_0_0_0_0);
    @(negedge clk);
    chk("rst-exec no done", {done0, done1}, 2'b00);
    rand_load(0); rand_load(1);
    set_req(0, 1'b1); set_req(1, 1'b1);
    reset = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    chk("post-rst gnt0 first", {gnt0, gnt1}, 2'b10);
    set_req(0, 1'b0);
    exp = model(s_l[0], s_op[0], s_a[0], s_b[0]);
    @(negedge clk);
    chk("post-rst done0 rzcs", {done0, r, z, c, s}, {1'b1, exp});
    @(negedge clk);
    chk("post-rst gnt1", {gnt0, gnt1}, 2'b01);
    set_req(1, 1'b0);
    exp = model(s_l[1], s_op[1], s_a[1], s_b[1]);
    @(negedge clk);
    chk("post-rst done1 rzcs", {done1, r, z, c, s}, {1'b1, exp});
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
